fb_scheduler: RTL and testbench

//  Triple-buffer frame scheduler for the AXI video delay path. It picks which DDR frame buffer the
//  AXI sink writes and which one the AXI source reads. Sink and source get their base addresses and

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_scheduler_if.sv | 27 ++
 rtl/srst_gen.sv | 39 +++
 rtl/fb_scheduler.sv | 136 +++++++++++++
 tb/tb_fb_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and address helpers for the triple-buffer frame scheduler and its sink/source peers.
package fb_pkg;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  // Buffer indices travel on 2-bit ports, so NBUF is limited to 3..4.
  localparam int IDX_W = 2;

  localparam int          H_WIDTH_DEF  = 1920;
  localparam int          V_HEIGHT_DEF = 1080;
  localparam logic [31:0] BASE_DEF     = 32'h2000_0000;

  function automatic logic [31:0] frame_size(input int h, input int v);
    return 32'(h * v * 3);
  endfunction

  // Wraps silently in 32 bits; callers own the DDR map.
  function automatic logic [31:0] buf_addr(input logic [31:0] base, input logic [31:0] size,
                                           input int idx);
    return base + 32'(idx) * size;
  endfunction

endpackage

// File: rtl/fb_scheduler_if.sv
// Control bundle between the frame scheduler and the video timing / AXI sink / AXI source.
interface fb_scheduler_if;

  logic                     vs_i;
  logic                     wen_i;
  logic                     ren_i;
  logic                     wr_done_i;
  logic [31:0]              wr_addr_o;
  logic [31:0]              rd_addr_o;
  logic [fb_pkg::IDX_W-1:0] wr_idx_o;
  logic [fb_pkg::IDX_W-1:0] rd_idx_o;
  logic                     srst_o;
  logic                     aval_o;
  logic                     drop_o;
  logic                     repeat_o;

  modport master (
    output vs_i, wen_i, ren_i, wr_done_i,
    input  wr_addr_o, rd_addr_o, wr_idx_o, rd_idx_o, srst_o, aval_o, drop_o, repeat_o
  );

  modport slave (
    input  vs_i, wen_i, ren_i, wr_done_i,
    output wr_addr_o, rd_addr_o, wr_idx_o, rd_idx_o, srst_o, aval_o, drop_o, repeat_o
  );

endinterface

// File: rtl/srst_gen.sv
// Vsync edge detector plus soft-reset stretcher: every vsync rise holds sink/source in reset
// for SRST_LEN cycles so they restart cleanly on the freshly selected buffers.
module srst_gen #(
  parameter int SRST_LEN = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_vs,
  output logic o_vs_rise,
  output logic o_srst,
  output logic o_aval
);

  localparam int CNT_W = $clog2(SRST_LEN + 1);

  logic             r_vs_q;
  logic             r_inited;
  logic [CNT_W-1:0] r_cnt;

  assign o_vs_rise = i_vs & ~r_vs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vs_q   <= 1'b0;
      r_inited <= 1'b0;
      r_cnt    <= CNT_W'(SRST_LEN);
    end else begin
      r_vs_q <= i_vs;
      if (i_vs) r_inited <= 1'b1;
      if (o_vs_rise)          r_cnt <= CNT_W'(SRST_LEN);
      else if (r_cnt != '0)   r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_srst = (r_cnt != '0);
  // Until the first vsync is seen the addresses are always considered valid.
  assign o_aval = ~r_inited | i_vs;

endmodule

// File: rtl/fb_scheduler.sv
// Triple-buffer frame scheduler: rotates DDR frame buffers on vsync, publishing a frame only once
// the sink has fully written it; the reader repeats on starvation and the writer drops on overrun.
module fb_scheduler
  import fb_pkg::*;
#(
  parameter int          H_WIDTH  = H_WIDTH_DEF,
  parameter int          V_HEIGHT = V_HEIGHT_DEF,
  parameter logic [31:0] BASE     = BASE_DEF,
  parameter int          NBUF     = 3,
  parameter int          SRST_LEN = 15
) (
  input logic           clk_i,
  input logic           rst_i,
  fb_scheduler_if.slave bus
);

  localparam logic [31:0] SIZE = frame_size(H_WIDTH, V_HEIGHT);

  typedef logic [IDX_W-1:0] idx_t;

  buf_state_t  r_state     [NBUF];
  buf_state_t  w_state_nxt [NBUF];
  logic [31:0] w_addr_tbl  [NBUF];

  idx_t        r_wr_idx, r_rd_idx;
  idx_t        w_wr_nxt, w_rd_nxt;
  idx_t        w_rdy_idx, w_free_idx;
  logic [31:0] r_wr_addr, r_rd_addr;
  logic        r_done, r_drop, r_repeat;
  logic        w_drop_nxt, w_repeat_nxt;
  logic        w_vs_rise, w_done_eff, w_publish;
  logic        w_rdy_found, w_free_found;

  srst_gen #(.SRST_LEN(SRST_LEN)) u_srst_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_vs      (bus.vs_i),
    .o_vs_rise (w_vs_rise),
    .o_srst    (bus.srst_o),
    .o_aval    (bus.aval_o)
  );

  for (genvar g = 0; g < NBUF; g++) begin : g_addr
    assign w_addr_tbl[g] = buf_addr(BASE, SIZE, g);
  end

  // A done pulse landing on the vsync rise still belongs to the frame that is ending.
  assign w_done_eff = r_done | bus.wr_done_i;
  assign w_publish  = w_vs_rise & bus.wen_i & w_done_eff;

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_nxt     = r_rd_idx;
    w_wr_nxt     = r_wr_idx;
    w_drop_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;

    if (w_vs_rise) begin
      for (int i = 0; i < NBUF; i++) begin
        if (!w_rdy_found && r_state[i] == BUF_READY) begin
          w_rdy_found = 1'b1;
          w_rdy_idx   = idx_t'(i);
        end
      end

      // Reader moves first so a READY frame it takes is never counted as dropped.
      if (bus.ren_i) begin
        if (w_rdy_found) begin
          w_state_nxt[r_rd_idx]  = BUF_FREE;
          w_state_nxt[w_rdy_idx] = BUF_READING;
          w_rd_nxt               = w_rdy_idx;
        end else begin
          w_repeat_nxt = 1'b1;
        end
      end

      if (w_publish) begin
        for (int i = 0; i < NBUF; i++) begin
          if (w_state_nxt[i] == BUF_READY) begin
            w_state_nxt[i] = BUF_FREE;
            w_drop_nxt     = 1'b1;
          end
        end
        w_state_nxt[r_wr_idx] = BUF_READY;
        for (int i = 0; i < NBUF; i++) begin
          if (!w_free_found && w_state_nxt[i] == BUF_FREE) begin
            w_free_found = 1'b1;
            w_free_idx   = idx_t'(i);
          end
        end
        if (w_free_found) begin
          w_state_nxt[w_free_idx] = BUF_WRITING;
          w_wr_nxt                = w_free_idx;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NBUF; i++)
        r_state[i] <= (i == 0) ? BUF_READING : (i == 1) ? BUF_WRITING : BUF_FREE;
      r_rd_idx  <= idx_t'(0);
      r_wr_idx  <= idx_t'(1);
      r_rd_addr <= w_addr_tbl[0];
      r_wr_addr <= w_addr_tbl[1];
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      // With NBUF>=3 a FREE buffer always survives the reader step.
      if (w_publish) assert (w_free_found);
      r_state   <= w_state_nxt;
      r_rd_idx  <= w_rd_nxt;
      r_wr_idx  <= w_wr_nxt;
      r_rd_addr <= w_addr_tbl[w_rd_nxt];
      r_wr_addr <= w_addr_tbl[w_wr_nxt];
      r_drop    <= w_drop_nxt;
      r_repeat  <= w_repeat_nxt;
      if (w_vs_rise)           r_done <= 1'b0;
      else if (bus.wr_done_i)  r_done <= 1'b1;
    end
  end

  assign bus.rd_idx_o  = r_rd_idx;
  assign bus.wr_idx_o  = r_wr_idx;
  assign bus.rd_addr_o = r_rd_addr;
  assign bus.wr_addr_o = r_wr_addr;
  assign bus.drop_o    = r_drop;
  assign bus.repeat_o  = r_repeat;

endmodule

// File: tb/tb_fb_scheduler.sv
// Directed scenarios plus a randomized vsync/done/enable soak against a frame-level reference model.
module tb_fb_scheduler;
  import fb_pkg::*;

  localparam int          NB   = 3;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] SZ   = 32'd6220800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_scheduler_if bus ();

  fb_scheduler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: which buffer is read, written, and (optionally) holding a finished frame.
  int m_rd, m_wr, m_ready, m_cnt;
  bit m_done, m_vsq, m_inited, m_drop, m_rep;

  function automatic logic [31:0] addr_of(input int i);
    return BASE + 32'(i) * SZ;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 1; m_ready = -1; m_cnt = 15;
    m_done = 0; m_vsq = 0; m_inited = 0; m_drop = 0; m_rep = 0;
  endtask

  task automatic model_step();
    bit rise;
    int nw;
    m_drop = 0;
    m_rep  = 0;
    if (rst) begin
      model_reset();
      return;
    end
    rise = bus.vs_i && !m_vsq;
    if (rise) begin
      if (bus.ren_i) begin
        if (m_ready >= 0) begin
          m_rd    = m_ready;
          m_ready = -1;
        end else m_rep = 1;
      end
      if (bus.wen_i && (m_done || bus.wr_done_i)) begin
        if (m_ready >= 0) m_drop = 1;
        m_ready = m_wr;
        nw = -1;
        for (int i = NB - 1; i >= 0; i--) if (i != m_rd && i != m_ready) nw = i;
        m_wr = nw;
      end
      m_done = 0;
      m_cnt  = 15;
    end else begin
      if (bus.wr_done_i) m_done = 1;
      if (m_cnt > 0) m_cnt--;
    end
    m_vsq = bus.vs_i;
    if (bus.vs_i) m_inited = 1;
  endtask

  task automatic check_all();
    buf_state_t exp_st;
    int n_rdg, n_wrg;
    chk("rd_idx",  32'(bus.rd_idx_o), 32'(m_rd));
    chk("wr_idx",  32'(bus.wr_idx_o), 32'(m_wr));
    chk("rd_addr", bus.rd_addr_o,     addr_of(m_rd));
    chk("wr_addr", bus.wr_addr_o,     addr_of(m_wr));
    chk("srst",    32'(bus.srst_o),   32'(m_cnt != 0));
    chk("aval",    32'(bus.aval_o),   32'(!m_inited || bus.vs_i));
    chk("drop",    32'(bus.drop_o),   32'(m_drop));
    chk("repeat",  32'(bus.repeat_o), 32'(m_rep));
    n_rdg = 0;
    n_wrg = 0;
    for (int i = 0; i < NB; i++) begin
      exp_st = (i == m_rd) ? BUF_READING : (i == m_wr) ? BUF_WRITING :
               (i == m_ready) ? BUF_READY : BUF_FREE;
      chk($sformatf("state%0d", i), 32'(dut.r_state[i]), 32'(exp_st));
      if (dut.r_state[i] == BUF_READING) n_rdg++;
      if (dut.r_state[i] == BUF_WRITING) n_wrg++;
    end
    chk("one_reading", 32'(n_rdg), 32'd1);
    chk("one_writing", 32'(n_wrg), 32'd1);
  endtask

  task automatic tick(input bit vs, input bit wen, input bit ren, input bit done);
    bus.vs_i      = vs;
    bus.wen_i     = wen;
    bus.ren_i     = ren;
    bus.wr_done_i = done;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One frame: vsync still high, then len low cycles, ending on the vsync rise.
  // done_at == len puts the done pulse on the rise cycle; -1 means no pulse.
  task automatic frame(input int done_at, input bit wen, input bit ren, input int len);
    tick(1'b1, wen, ren, 1'b0);
    for (int c = 0; c < len; c++) tick(1'b0, wen, ren, c == done_at);
    tick(1'b1, wen, ren, done_at == len);
  endtask

  initial begin
    int n;
    int len;
    int dat;
    bus.vs_i = 0; bus.wen_i = 0; bus.ren_i = 0; bus.wr_done_i = 0;
    model_reset();

    // Reset values
    rst = 1'b1;
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    chk("rst_rd_idx",  32'(bus.rd_idx_o), 32'd0);
    chk("rst_wr_idx",  32'(bus.wr_idx_o), 32'd1);
    chk("rst_rd_addr", bus.rd_addr_o,     32'h2000_0000);
    chk("rst_wr_addr", bus.wr_addr_o,     32'h205E_EC00);
    chk("rst_srst",    32'(bus.srst_o),   32'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick(0, 1, 1, 0);

    // Vsync without a finished frame: reader repeats, soft reset held 15 cycles
    tick(1, 1, 1, 0);
    chk("first_repeat", 32'(bus.repeat_o), 32'd1);
    chk("first_wr_idx", 32'(bus.wr_idx_o), 32'd1);
    n = 0;
    while (bus.srst_o && n < 40) begin
      n++;
      tick(n < 3, 1, 1, 0);
    end
    chk("srst_len", 32'(n), 32'd15);

    // Publish buf1, then reader takes it
    frame(5, 1, 1, 20);
    chk("pub_wr_idx",  32'(bus.wr_idx_o), 32'd2);
    chk("pub_wr_addr", bus.wr_addr_o,     32'h20BD_D800);
    chk("pub_ready1",  32'(dut.r_state[1]), 32'(BUF_READY));
    frame(-1, 1, 1, 20);
    chk("take_rd_idx", 32'(bus.rd_idx_o), 32'd1);
    chk("take_free0",  32'(dut.r_state[0]), 32'(BUF_FREE));

    // Reader frozen, two completed frames: second one drops the first
    frame(5, 1, 0, 20);
    frame(5, 1, 0, 20);
    chk("ovr_drop",   32'(bus.drop_o),   32'd1);
    chk("ovr_rd_idx", 32'(bus.rd_idx_o), 32'd1);
    chk("ovr_ready0", 32'(dut.r_state[0]), 32'(BUF_READY));

    // Done coinciding with the vsync rise still publishes; the flag does not carry over
    frame(20, 1, 1, 20);
    chk("coinc_ready2", 32'(dut.r_state[2]), 32'(BUF_READY));
    frame(-1, 1, 0, 20);
    chk("coinc_ready2_kept", 32'(dut.r_state[2]), 32'(BUF_READY));
    chk("coinc_wr_idx", 32'(bus.wr_idx_o), 32'd1);

    // Writer disabled: no publish, no drop over three vsyncs
    for (int f = 0; f < 3; f++) begin
      frame(5, 0, 1, 15);
      chk("wen0_drop", 32'(bus.drop_o), 32'd0);
    end

    // Reset mid-frame with a READY buffer pending
    frame(5, 1, 0, 15);
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 1);
    rst = 1'b1;
    tick(0, 1, 1, 0);
    rst = 1'b0;
    chk("mid_rst_rd_idx", 32'(bus.rd_idx_o), 32'd0);
    chk("mid_rst_wr_idx", 32'(bus.wr_idx_o), 32'd1);
    chk("mid_rst_drop",   32'(bus.drop_o),   32'd0);
    chk("mid_rst_repeat", 32'(bus.repeat_o), 32'd0);
    chk("mid_rst_free2",  32'(dut.r_state[2]), 32'(BUF_FREE));

    // Random soak
    for (int f = 0; f < 150; f++) begin
      len = int'($urandom_range(4, 30));
      case ($urandom_range(0, 3))
        0:       dat = -1;
        1:       dat = len;
        default: dat = int'($urandom_range(0, len - 1));
      endcase
      frame(dat, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, len);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick(0, 1, 1, 0);
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
